riscv_v_exe_uop_seq: RTL and testbench

//  Register-group micro-op sequencer in front of the vector EXE ALU. Accepts one vector instruction
//  (vl, SEW as osize one-hot, LMUL, base vd/vs1/vs2) and issues one micro-op per physical register of
//  the group. Each micro-op carries the per-byte valid mask that drives mask_result_valid_exe.

---
 rtl/riscv_v_exe_uop_seq_pkg.sv | 55 +++++
 rtl/riscv_v_exe_uop_seq_if.sv | 37 +++
 rtl/riscv_v_byte_valid_gen.sv | 17 +
 rtl/riscv_v_exe_uop_seq.sv | 142 ++++++++++++++
 tb/tb_riscv_v_exe_uop_seq.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_v_exe_uop_seq_pkg.sv
// Shared vector-unit types: osize one-hot encodings, sequencer state and micro-op record.
package riscv_v_pkg;

  localparam int unsigned RISCV_V_VLEN             = 128;
  localparam int unsigned RISCV_V_NUM_BYTES        = RISCV_V_VLEN / 8;
  localparam int unsigned RISCV_V_MAX_LMUL_LOG2    = 3;
  localparam int unsigned RISCV_V_VL_W             = 8;
  localparam int unsigned RISCV_V_NUM_VALID_OSIZES = 5;

  typedef enum logic [2:0] {
    OSIZE_IDX_8   = 3'd0,
    OSIZE_IDX_16  = 3'd1,
    OSIZE_IDX_32  = 3'd2,
    OSIZE_IDX_64  = 3'd3,
    OSIZE_IDX_128 = 3'd4
  } osize_idx_e;

  typedef enum logic [RISCV_V_NUM_VALID_OSIZES-1:0] {
    OSIZE_8B   = 5'b00001,
    OSIZE_16B  = 5'b00010,
    OSIZE_32B  = 5'b00100,
    OSIZE_64B  = 5'b01000,
    OSIZE_128B = 5'b10000
  } osize_onehot_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } uop_seq_state_t;

  typedef struct packed {
    logic [4:0]                       vd;
    logic [4:0]                       vs1;
    logic [4:0]                       vs2;
    logic [RISCV_V_MAX_LMUL_LOG2-1:0] idx;
    logic                             first;
    logic                             last;
    logic [RISCV_V_NUM_BYTES-1:0]     byte_valid;
  } uop_t;

  // Anything that is not a clean one-hot falls back to byte elements.
  function automatic osize_idx_e osize_onehot_to_log2(
    input logic [RISCV_V_NUM_VALID_OSIZES-1:0] osize
  );
    case (osize)
      OSIZE_16B:  return OSIZE_IDX_16;
      OSIZE_32B:  return OSIZE_IDX_32;
      OSIZE_64B:  return OSIZE_IDX_64;
      OSIZE_128B: return OSIZE_IDX_128;
      default:    return OSIZE_IDX_8;
    endcase
  endfunction

endpackage

// File: rtl/riscv_v_exe_uop_seq_if.sv
// Instruction-in / micro-op-out handshake bundle of the register-group sequencer.
interface riscv_v_exe_uop_seq_if #(
  parameter int unsigned NUM_BYTES = 16,
  parameter int unsigned VL_W      = 8,
  parameter int unsigned IDX_W     = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [VL_W-1:0]      in_vl;
  logic [4:0]           in_osize_vector;
  logic [1:0]           in_lmul_log2;
  logic [4:0]           in_vd;
  logic [4:0]           in_vs1;
  logic [4:0]           in_vs2;

  logic                 uop_valid;
  logic                 uop_ready;
  logic [4:0]           uop_vd;
  logic [4:0]           uop_vs1;
  logic [4:0]           uop_vs2;
  logic [IDX_W-1:0]     uop_idx;
  logic                 uop_first;
  logic                 uop_last;
  logic [NUM_BYTES-1:0] uop_byte_valid;

  modport slave (
    input  in_valid, in_vl, in_osize_vector, in_lmul_log2, in_vd, in_vs1, in_vs2, uop_ready,
    output in_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_idx, uop_first, uop_last,
           uop_byte_valid
  );

  modport master (
    output in_valid, in_vl, in_osize_vector, in_lmul_log2, in_vd, in_vs1, in_vs2, uop_ready,
    input  in_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_idx, uop_first, uop_last,
           uop_byte_valid
  );
endinterface

// File: rtl/riscv_v_byte_valid_gen.sv
// Remaining-byte count to per-byte thermometer mask for one register of a group.
module riscv_v_byte_valid_gen #(
  parameter int unsigned NUM_BYTES = 16,
  parameter int unsigned REM_W     = 13
) (
  input  logic [REM_W-1:0]     remaining,
  output logic [NUM_BYTES-1:0] byte_valid
);

  always_comb begin
    byte_valid = '0;
    for (int unsigned b = 0; b < NUM_BYTES; b++) begin
      byte_valid[b] = (32'(remaining) > b);
    end
  end

endmodule

// File: rtl/riscv_v_exe_uop_seq.sv
// Register-group micro-op sequencer: splits one vector instruction into one micro-op per
// physical register, each with a registered per-byte valid mask.
module riscv_v_exe_uop_seq
  import riscv_v_pkg::*;
#(
  parameter int unsigned VLEN          = RISCV_V_VLEN,
  parameter int unsigned NUM_BYTES     = VLEN / 8,
  parameter int unsigned MAX_LMUL_LOG2 = RISCV_V_MAX_LMUL_LOG2,
  parameter int unsigned VL_W          = RISCV_V_VL_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  riscv_v_exe_uop_seq_if.slave bus,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned W = VL_W + 5;

  uop_seq_state_t   state_q, state_d;
  logic             uop_valid_q, uop_valid_d;
  logic             done_q, done_d;
  uop_t             uop_q, uop_d, uop_ctrl;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     cap, vl_eff, tot_bytes;
  osize_idx_e       elog2;
  logic [1:0]       lmul_eff;
  logic             in_ready, accept, fire, load_mask;
  logic [NUM_BYTES-1:0] mask;

  riscv_v_byte_valid_gen #(
    .NUM_BYTES (NUM_BYTES),
    .REM_W     (W)
  ) u_byte_valid_gen (
    .remaining  (rem_d),
    .byte_valid (mask)
  );

  always_comb begin
    elog2     = osize_onehot_to_log2(bus.in_osize_vector);
    lmul_eff  = (int'(bus.in_lmul_log2) > int'(MAX_LMUL_LOG2)) ? 2'(MAX_LMUL_LOG2)
                                                              : bus.in_lmul_log2;
    cap       = (W'(NUM_BYTES) >> elog2) << lmul_eff;
    vl_eff    = (W'(bus.in_vl) < cap) ? W'(bus.in_vl) : cap;
    tot_bytes = vl_eff << elog2;
  end

  always_comb begin
    state_d     = state_q;
    uop_valid_d = uop_valid_q;
    done_d      = 1'b0;
    rem_d       = rem_q;
    uop_ctrl    = uop_q;
    load_mask   = 1'b0;
    in_ready    = rst && !flush && (state_q == IDLE || state_q == DONE);
    accept      = bus.in_valid && in_ready;
    fire        = uop_valid_q && bus.uop_ready;

    if (flush) begin
      state_d     = IDLE;
      uop_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (accept) begin
            if (vl_eff == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d        = ISSUE;
              uop_valid_d    = 1'b1;
              rem_d          = tot_bytes;
              load_mask      = 1'b1;
              uop_ctrl.vd    = bus.in_vd;
              uop_ctrl.vs1   = bus.in_vs1;
              uop_ctrl.vs2   = bus.in_vs2;
              uop_ctrl.idx   = '0;
              uop_ctrl.first = 1'b1;
              uop_ctrl.last  = (tot_bytes <= W'(NUM_BYTES));
            end
          end
        end
        ISSUE: begin
          if (fire) begin
            if (uop_q.last) begin
              state_d     = DONE;
              done_d      = 1'b1;
              uop_valid_d = 1'b0;
            end else begin
              // Remaining bytes are tracked instead of a uop count; last is simply "fits in one register".
              rem_d          = rem_q - W'(NUM_BYTES);
              load_mask      = 1'b1;
              uop_ctrl.vd    = uop_q.vd + 5'd1;
              uop_ctrl.vs1   = uop_q.vs1 + 5'd1;
              uop_ctrl.vs2   = uop_q.vs2 + 5'd1;
              uop_ctrl.idx   = uop_q.idx + 1'b1;
              uop_ctrl.first = 1'b0;
              uop_ctrl.last  = (rem_d <= W'(NUM_BYTES));
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    uop_d = uop_ctrl;
    if (load_mask) uop_d.byte_valid = mask;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      uop_valid_q <= 1'b0;
      done_q      <= 1'b0;
      uop_q       <= '0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      uop_valid_q <= uop_valid_d;
      done_q      <= done_d;
      uop_q       <= uop_d;
      rem_q       <= rem_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.uop_valid      = uop_valid_q;
  assign bus.uop_vd         = uop_q.vd;
  assign bus.uop_vs1        = uop_q.vs1;
  assign bus.uop_vs2        = uop_q.vs2;
  assign bus.uop_idx        = uop_q.idx;
  assign bus.uop_first      = uop_q.first;
  assign bus.uop_last       = uop_q.last;
  assign bus.uop_byte_valid = uop_q.byte_valid;
  assign busy               = (state_q != IDLE);
  assign done               = done_q;

endmodule

// File: tb/tb_riscv_v_exe_uop_seq.sv
// Scoreboard bench for the register-group micro-op sequencer.
module tb_riscv_v_exe_uop_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic busy, done;

  riscv_v_exe_uop_seq_if #(.NUM_BYTES(16), .VL_W(8), .IDX_W(3)) bus ();

  riscv_v_exe_uop_seq #(
    .VLEN(128), .NUM_BYTES(16), .MAX_LMUL_LOG2(3), .VL_W(8)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    int unsigned vd, vs1, vs2, idx;
    bit          first, last;
    int unsigned mask;
  } exp_t;

  exp_t        expq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ready_mode = 0;
  int unsigned ready_cnt = 0;
  bit          rst_prev = 1'b1;
  bit          f_uop, f_done;
  exp_t        fe;

  function automatic void chk(string name, int unsigned act, int unsigned expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Reference: element size, clamp, byte total and per-register slices from plain arithmetic.
  function automatic void push_model(int unsigned vl, logic [4:0] os, int unsigned lm,
                                     int unsigned vd, int unsigned vs1, int unsigned vs2);
    int unsigned eb, ones, cap, vle, tot, n, rem;
    exp_t e;
    eb = 1; ones = 0;
    for (int i = 0; i < 5; i++) if (os[i]) begin ones++; eb = 1 << i; end
    if (ones != 1) eb = 1;
    cap = (16 / eb) * (1 << lm);
    vle = (vl < cap) ? vl : cap;
    tot = vle * eb;
    n   = (tot + 15) / 16;
    for (int unsigned i = 0; i < n; i++) begin
      rem = tot - 16 * i;
      e = '{1'b0, (vd + i) % 32, (vs1 + i) % 32, (vs2 + i) % 32, i, (i == 0), (i == n - 1),
            (rem >= 16) ? 32'hFFFF : ((32'd1 << rem) - 1)};
      expq.push_back(e);
    end
    e = '{1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 0};
    expq.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_in_reset", 32'(bus.in_ready), 0);
      if (!rst_prev) begin
        chk("uop_valid_rst", 32'(bus.uop_valid), 0);
        chk("done_rst", 32'(done), 0);
        chk("busy_rst", 32'(busy), 0);
        chk("uop_regs_rst", 32'({bus.uop_vd, bus.uop_vs1, bus.uop_vs2, bus.uop_idx,
                                 bus.uop_first, bus.uop_last}), 0);
        chk("uop_mask_rst", 32'(bus.uop_byte_valid), 0);
      end
      expq.delete();
    end else begin
      f_uop  = (expq.size() != 0) && !expq[0].is_done;
      f_done = (expq.size() != 0) && expq[0].is_done;
      chk("in_ready", 32'(bus.in_ready), 32'(!flush && !f_uop));
      chk("busy", 32'(busy), 32'(expq.size() != 0));
      chk("uop_valid", 32'(bus.uop_valid), 32'(f_uop));
      chk("done", 32'(done), 32'(f_done));
      if (f_uop) begin
        fe = expq[0];
        chk("uop_vd", 32'(bus.uop_vd), fe.vd);
        chk("uop_vs1", 32'(bus.uop_vs1), fe.vs1);
        chk("uop_vs2", 32'(bus.uop_vs2), fe.vs2);
        chk("uop_idx", 32'(bus.uop_idx), fe.idx);
        chk("uop_first", 32'(bus.uop_first), 32'(fe.first));
        chk("uop_last", 32'(bus.uop_last), 32'(fe.last));
        chk("uop_byte_valid", 32'(bus.uop_byte_valid), fe.mask);
        if (bus.uop_valid && bus.uop_ready && !flush) void'(expq.pop_front());
      end else if (f_done && done) begin
        void'(expq.pop_front());
      end
      if (flush) expq.delete();
    end
    rst_prev = rst;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.uop_ready = 1'b1;
        1:       bus.uop_ready = 1'($urandom_range(0, 1));
        default: bus.uop_ready = (ready_cnt % 3 == 0);
      endcase
      ready_cnt++;
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input int unsigned vl, input logic [4:0] os, input int unsigned lm,
                       input int unsigned vd, input int unsigned vs1, input int unsigned vs2);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_vl = 8'(vl);
    bus.in_osize_vector = os;
    bus.in_lmul_log2 = 2'(lm);
    bus.in_vd = 5'(vd);
    bus.in_vs1 = 5'(vs1);
    bus.in_vs2 = 5'(vs2);
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
    end
    if (ok) push_model(vl & 32'hFF, os, lm, vd, vs1, vs2);
    else begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready never seen, required within 200 cycles");
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    ready_mode = 0;
    for (int k = 0; k < 100 && expq.size() != 0; k++) idle(1);
    idle(2);
    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected items left, required 0", expq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_vl = '0; bus.in_osize_vector = 5'b00001;
    bus.in_lmul_log2 = '0; bus.in_vd = '0; bus.in_vs1 = '0; bus.in_vs2 = '0;
    bus.uop_ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    ready_mode = 0;
    issue(8, 5'b00100, 1, 4, 8, 12);    idle(5);
    issue(13, 5'b00010, 2, 1, 2, 3);    idle(5);
    issue(0, 5'b00001, 3, 7, 7, 7);     idle(3);
    ready_mode = 2;
    issue(128, 5'b00001, 3, 30, 0, 16); drain();

    issue(64, 5'b00001, 2, 10, 11, 12);
    idle(2);
    chk("flush_at_idx2", 32'(bus.uop_idx), 2);
    pulse_flush();
    issue(16, 5'b00001, 0, 1, 1, 1);    drain();

    issue(200, 5'b01000, 0, 3, 4, 5);
    issue(5, 5'b00100, 1, 9, 9, 9);     drain();
    issue(20, 5'b00011, 3, 31, 31, 31); drain();

    for (int it = 0; it < 150; it++) begin
      int unsigned vl;
      logic [4:0]  os;
      ready_mode = int'($urandom_range(0, 2));
      vl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
      os = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                       : 5'(32'd1 << $urandom_range(0, 4));
      issue(vl, os, $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31));
      if (it == 75) begin
        idle(1);
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(0, 5));
        pulse_flush();
      end else begin
        idle($urandom_range(0, 2));
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
